vec_result_writer: RTL and testbench



---
 rtl/vec_pkg.sv | 22 ++
 rtl/vec_result_writer_if.sv | 26 ++
 rtl/vec_lane_sel.sv | 12 +
 rtl/vec_result_writer.sv | 95 +++++++++
 tb/tb_vec_result_writer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared vector-datapath constants and types used by the ALU and its result writer.
package vec_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned VEC_W  = LANES * DATA_W;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned IDX_W  = $clog2(2 * LANES);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  // Captured ALU result pair; hi occupies the upper half so lane index idx >= LANES selects hi.
  typedef struct packed {
    logic [VEC_W-1:0] hi;
    logic [VEC_W-1:0] lo;
  } res_pair_t;

endpackage

// File: rtl/vec_result_writer_if.sv
// ALU result-pair handshake bundle and word-wide memory write bundle.
interface vec_res_if;
  import vec_pkg::*;

  logic              res_valid;
  logic              res_ready;
  logic [VEC_W-1:0]  res_lo;
  logic [VEC_W-1:0]  res_hi;
  logic [ADDR_W-1:0] base_addr;
  logic              wide;

  modport master (output res_valid, res_lo, res_hi, base_addr, wide, input res_ready);
  modport slave  (input res_valid, res_lo, res_hi, base_addr, wide, output res_ready);
endinterface

interface vec_mem_if;
  import vec_pkg::*;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (output mem_wr_en, mem_addr, mem_wdata, input mem_ready);
  modport slave  (input mem_wr_en, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/vec_lane_sel.sv
// Picks one DATA_W lane out of the concatenated {hi, lo} result buffer.
module vec_lane_sel
  import vec_pkg::*;
(
  input  logic [2*VEC_W-1:0] vec,
  input  logic [IDX_W-1:0]   idx,
  output logic [DATA_W-1:0]  word_c
);

  assign word_c = vec[32'(idx) * DATA_W +: DATA_W];

endmodule

// File: rtl/vec_result_writer.sv
// Captures a vector ALU result pair and serializes it lane by lane into
// consecutive data-memory word writes.
module vec_result_writer
  import vec_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  vec_res_if.slave  res,
  vec_mem_if.master mem,
  output logic      busy,
  output logic      done
);

  state_e            state_q;
  state_e            state_d;
  res_pair_t         buf_q;
  logic [ADDR_W-1:0] base_q;
  logic              wide_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  last_c;
  logic              take_c;
  logic              accept_c;
  logic [DATA_W-1:0] word_c;

  assign last_c = wide_q ? IDX_W'(2 * LANES - 1) : IDX_W'(LANES - 1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-state handshake outputs
  always_comb begin
    state_d       = state_q;
    res.res_ready = 1'b0;
    mem.mem_wr_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    take_c        = 1'b0;
    accept_c      = 1'b0;
    case (state_q)
      IDLE: begin
        res.res_ready = 1'b1;
        if (res.res_valid) begin
          take_c  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy          = 1'b1;
        mem.mem_wr_en = 1'b1;
        if (mem.mem_ready) begin
          accept_c = 1'b1;
          if (idx_q == last_c) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture registers and word index; idx holds at last so DONE sees a stable value
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      base_q <= '0;
      wide_q <= 1'b0;
      idx_q  <= '0;
    end else if (take_c) begin
      buf_q.lo <= res.res_lo;
      buf_q.hi <= res.res_hi;
      base_q   <= res.base_addr;
      wide_q   <= res.wide;
      idx_q    <= '0;
    end else if (accept_c && (idx_q != last_c)) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  vec_lane_sel u_lane_sel (
    .vec    (buf_q),
    .idx    (idx_q),
    .word_c (word_c)
  );

  // Address wraps naturally in ADDR_W bits
  assign mem.mem_addr  = base_q + ADDR_W'(idx_q);
  assign mem.mem_wdata = word_c;

endmodule

// File: tb/tb_vec_result_writer.sv
// Randomized scoreboard bench for vec_result_writer: expected memory writes are
// queued at capture time and popped by an independent write monitor.
module tb_vec_result_writer;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;

  vec_res_if res ();
  vec_mem_if mem ();

  vec_result_writer dut (
    .clk  (clk),
    .rst  (rst),
    .res  (res),
    .mem  (mem),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned       addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  stall_addr = -1;
  int  stall_left = 0;
  int  rdy_pct    = 100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: scripted stall on one address, otherwise random acceptance
  initial begin
    mem.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem.mem_wr_en && stall_left > 0 && int'(mem.mem_addr) == stall_addr) begin
        mem.mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem.mem_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      end
    end
  end

  // Monitor: every accepted write is compared in order against the scoreboard
  initial begin
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_wr_en", mem.mem_wr_en, 1);
        check("stall_addr", mem.mem_addr, prev_addr);
        check("stall_data", mem.mem_wdata, prev_data);
      end
      if (mem.mem_wr_en) begin
        check("busy_during_write", busy, 1);
        if (mem.mem_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem.mem_addr, mem.mem_wdata);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", mem.mem_addr, e.addr);
            check("write_data", mem.mem_wdata, e.data);
          end
        end
      end
      prev_stall = mem.mem_wr_en && !mem.mem_ready;
      prev_addr  = mem.mem_addr;
      prev_data  = mem.mem_wdata;
      if (done) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done pulse at cycle %0d with no transfer pending", cyc);
        end else begin
          int e;
          e = done_q.pop_front();
          check("done_after_all_words", exp_q.size(), 0);
          check("done_busy", busy, 1);
          check("done_no_write", mem.mem_wr_en, 0);
          if (e >= 0) check("done_cycle", cyc, e);
        end
      end
    end
  end

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = $urandom();
    return v;
  endfunction

  // Offer a pair, wait for the handshake, then queue the expected word stream
  task automatic issue(input logic [VEC_W-1:0] lo, input logic [VEC_W-1:0] hi,
                       input int unsigned base, input bit w,
                       input int s_addr, input int s_len, input int pct);
    int guard;
    int n;
    int words;
    guard = 0;
    res.res_lo    = lo;
    res.res_hi    = hi;
    res.base_addr = ADDR_W'(base);
    res.wide      = w;
    res.res_valid = 1'b1;
    while (!res.res_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!res.res_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: res_ready low for %0d cycles", guard);
      res.res_valid = 1'b0;
      return;
    end
    stall_addr = s_addr;
    stall_left = s_len;
    rdy_pct    = pct;
    n     = cyc + 1;
    words = w ? 2 * LANES : LANES;
    for (int i = 0; i < words; i++) begin
      wr_t e;
      e.addr = (base + i) % (1 << ADDR_W);
      e.data = (i < LANES) ? lo[i*DATA_W +: DATA_W] : hi[(i-LANES)*DATA_W +: DATA_W];
      exp_q.push_back(e);
    end
    done_q.push_back(pct == 100 ? n + words + s_len : -1);
    @(negedge clk);
    res.res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: %0d words and %0d done pulses pending", exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [VEC_W-1:0] inc_vec;
    logic [VEC_W-1:0] a_vec;
    logic [VEC_W-1:0] ones_vec;
    int unsigned      rbase;
    int               guard;

    for (int i = 0; i < LANES; i++) begin
      inc_vec[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
      a_vec[i*DATA_W +: DATA_W]   = 32'hA000_0000 + DATA_W'(i);
    end
    ones_vec = '1;

    rst           = 1'b1;
    res.res_valid = 1'b0;
    res.res_lo    = '0;
    res.res_hi    = '0;
    res.base_addr = '0;
    res.wide      = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_res_ready", res.res_ready, 1);
    check("reset_wr_en", mem.mem_wr_en, 0);
    check("reset_addr", mem.mem_addr, 0);
    check("reset_wdata", mem.mem_wdata, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Narrow transfer, lanes 1..16
    issue(inc_vec, rand_vec(), 32'h010, 1'b0, -1, 0, 100);
    wait_idle();

    // Wide transfer, lo then all-ones hi
    issue(a_vec, ones_vec, 32'h100, 1'b1, -1, 0, 100);
    wait_idle();

    // Three-cycle stall on the sixth word
    issue(inc_vec, rand_vec(), 32'h010, 1'b0, 32'h015, 3, 100);
    wait_idle();

    // Address wrap past the top of memory
    issue(rand_vec(), rand_vec(), 32'h3F8, 1'b1, -1, 0, 100);
    wait_idle();

    // A competing pair offered mid-transfer must be ignored
    issue(rand_vec(), rand_vec(), 32'h050, 1'b1, -1, 0, 80);
    res.res_lo    = rand_vec();
    res.res_hi    = rand_vec();
    res.base_addr = ADDR_W'(32'h2A0);
    res.wide      = 1'b0;
    res.res_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_blocks_ready", res.res_ready, 0);
    res.res_valid = 1'b0;
    wait_idle();

    // Reset at word 7 of a wide transfer abandons it without a done pulse
    issue(rand_vec(), rand_vec(), 32'h200, 1'b1, -1, 0, 100);
    guard = 0;
    while (!(mem.mem_wr_en && mem.mem_addr == ADDR_W'(32'h207)) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reached_word7", mem.mem_addr, 32'h207);
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    check("midreset_wr_en", mem.mem_wr_en, 0);
    check("midreset_res_ready", res.res_ready, 1);
    check("midreset_done", done, 0);
    check("midreset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    issue(rand_vec(), rand_vec(), 32'h040, 1'b1, -1, 0, 100);
    wait_idle();

    // Random back-to-back traffic with random backpressure
    for (int t = 0; t < 10; t++) begin
      rbase = $urandom_range(0, 1023);
      issue(rand_vec(), rand_vec(), rbase, 1'($urandom_range(0, 1)), -1, 0,
            int'($urandom_range(40, 100)));
    end
    wait_idle();

    check("final_words_pending", exp_q.size(), 0);
    check("final_done_pending", done_q.size(), 0);
    check("final_res_ready", res.res_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
